// File: rtl/watch_time_counter.sv
// Calendar watch counter: second..year advanced by a synchronised 1 Hz tick,
// with a sanitising parallel load. Leap years follow the Gregorian rule on the 8-bit year.
module watch_time_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk1sec,
    input  logic [47:0] bin_time,
    input  logic        en_time,
    output logic [7:0]  year,
    output logic [7:0]  month,
    output logic [7:0]  day,
    output logic [7:0]  hour,
    output logic [7:0]  minute,
    output logic [7:0]  second,
    output logic        sec_pulse,
    output logic        day_pulse
);

    function automatic logic is_leap(input logic [7:0] y);
        logic [8:0] y9;
        y9 = {1'b0, y};
        is_leap = ((y[1:0] == 2'd0) && ((y % 8'd100) != 8'd0)) || ((y9 % 9'd400) == 9'd0);
    endfunction

    function automatic logic [7:0] max_date(input logic [7:0] m, input logic [7:0] y);
        case (m)
            8'd4, 8'd6, 8'd9, 8'd11: max_date = 8'd30;
            8'd2:                    max_date = is_leap(y) ? 8'd29 : 8'd28;
            default:                 max_date = 8'd31;
        endcase
    endfunction

    logic       r_sync_q1, r_sync_q2, r_prev;
    logic [7:0] r_year, r_month, r_day, r_hour, r_minute, r_second;
    logic       r_sec_pulse, r_day_pulse;

    logic       w_tick;
    logic [7:0] w_year, w_month, w_day, w_hour, w_minute, w_second;
    logic       w_sec_pulse, w_day_pulse;
    logic [7:0] w_ld_month, w_ld_max, w_cur_max;

    assign w_tick    = r_sync_q2 & ~r_prev;
    assign w_cur_max = max_date(r_month, r_year);

    // Sanitised load fields; day clamps against the already-sanitised month.
    assign w_ld_month = ((bin_time[39:32] == 8'd0) || (bin_time[39:32] > 8'd12)) ? 8'd1 : bin_time[39:32];
    assign w_ld_max   = max_date(w_ld_month, bin_time[47:40]);

    // Synchroniser and rising-edge detector for the 1 Hz input.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync_q1 <= 1'b0;
            r_sync_q2 <= 1'b0;
            r_prev    <= 1'b0;
        end else begin
            r_sync_q1 <= clk1sec;
            r_sync_q2 <= r_sync_q1;
            r_prev    <= r_sync_q2;
        end
    end

    // Next-time computation: load has priority and swallows a coincident tick.
    always_comb begin
        w_year      = r_year;
        w_month     = r_month;
        w_day       = r_day;
        w_hour      = r_hour;
        w_minute    = r_minute;
        w_second    = r_second;
        w_sec_pulse = 1'b0;
        w_day_pulse = 1'b0;
        if (en_time) begin
            w_year   = bin_time[47:40];
            w_month  = w_ld_month;
            w_day    = (bin_time[31:24] == 8'd0) ? 8'd1 :
                       ((bin_time[31:24] > w_ld_max) ? w_ld_max : bin_time[31:24]);
            w_hour   = (bin_time[23:16] > 8'd23) ? 8'd0 : bin_time[23:16];
            w_minute = (bin_time[15:8]  > 8'd59) ? 8'd0 : bin_time[15:8];
            w_second = (bin_time[7:0]   > 8'd59) ? 8'd0 : bin_time[7:0];
        end else if (w_tick) begin
            w_sec_pulse = 1'b1;
            if (r_second == 8'd59) begin
                w_second = 8'd0;
                if (r_minute == 8'd59) begin
                    w_minute = 8'd0;
                    if (r_hour == 8'd23) begin
                        w_hour      = 8'd0;
                        w_day_pulse = 1'b1;
                        if (r_day >= w_cur_max) begin
                            w_day = 8'd1;
                            if (r_month >= 8'd12) begin
                                w_month = 8'd1;
                                w_year  = r_year + 8'd1;
                            end else begin
                                w_month = r_month + 8'd1;
                            end
                        end else begin
                            w_day = r_day + 8'd1;
                        end
                    end else begin
                        w_hour = r_hour + 8'd1;
                    end
                end else begin
                    w_minute = r_minute + 8'd1;
                end
            end else begin
                w_second = r_second + 8'd1;
            end
        end else begin
            w_sec_pulse = 1'b0;
            w_day_pulse = 1'b0;
        end
    end

    // Time and pulse registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_year      <= 8'd1;
            r_month     <= 8'd1;
            r_day       <= 8'd1;
            r_hour      <= 8'd0;
            r_minute    <= 8'd0;
            r_second    <= 8'd0;
            r_sec_pulse <= 1'b0;
            r_day_pulse <= 1'b0;
        end else begin
            r_year      <= w_year;
            r_month     <= w_month;
            r_day       <= w_day;
            r_hour      <= w_hour;
            r_minute    <= w_minute;
            r_second    <= w_second;
            r_sec_pulse <= w_sec_pulse;
            r_day_pulse <= w_day_pulse;
        end
    end

    assign year      = r_year;
    assign month     = r_month;
    assign day       = r_day;
    assign hour      = r_hour;
    assign minute    = r_minute;
    assign second    = r_second;
    assign sec_pulse = r_sec_pulse;
    assign day_pulse = r_day_pulse;

endmodule

// File: tb/tb_watch_time_counter.sv
// Directed self-checking bench for watch_time_counter; outputs are sampled on the falling clock edge.
module tb_watch_time_counter;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk1sec;
    logic [47:0] bin_time;
    logic        en_time;
    logic [7:0]  year, month, day, hour, minute, second;
    logic        sec_pulse, day_pulse;

    int n_cmp = 0;
    int n_err = 0;

    watch_time_counter dut (
        .clk       (clk),
        .rst       (rst),
        .clk1sec   (clk1sec),
        .bin_time  (bin_time),
        .en_time   (en_time),
        .year      (year),
        .month     (month),
        .day       (day),
        .hour      (hour),
        .minute    (minute),
        .second    (second),
        .sec_pulse (sec_pulse),
        .day_pulse (day_pulse)
    );

    always #5 clk = ~clk;

    function automatic logic [47:0] tv(input int y, input int mo, input int d,
                                       input int h, input int mi, input int s);
        tv = {y[7:0], mo[7:0], d[7:0], h[7:0], mi[7:0], s[7:0]};
    endfunction

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Raise clk1sec just after a falling edge, sample after the 3rd rising edge, then drop it.
    task automatic tick_and_check(input string tag, input logic [47:0] exp_t, input logic exp_day);
        clk1sec = 1'b1;
        cycles(3);
        chk({tag, "_time"}, {year, month, day, hour, minute, second}, exp_t);
        chk({tag, "_sec_pulse"}, {47'd0, sec_pulse}, {47'd0, 1'b1});
        chk({tag, "_day_pulse"}, {47'd0, day_pulse}, {47'd0, exp_day});
        clk1sec = 1'b0;
        cycles(1);
        chk({tag, "_pulse_end"}, {46'd0, sec_pulse, day_pulse}, 48'd0);
        cycles(3);
    endtask

    task automatic load(input logic [47:0] v);
        bin_time = v;
        en_time  = 1'b1;
        cycles(1);
        en_time  = 1'b0;
    endtask

    initial begin
        rst      = 1'b0;
        clk1sec  = 1'b0;
        bin_time = 48'd0;
        en_time  = 1'b0;
        cycles(2);
        chk("reset_time", {year, month, day, hour, minute, second}, tv(1, 1, 1, 0, 0, 0));
        chk("reset_pulses", {46'd0, sec_pulse, day_pulse}, 48'd0);
        rst = 1'b1;
        cycles(2);

        // First tick: invisible after edges 1 and 2, visible on edge 3.
        clk1sec = 1'b1;
        cycles(2);
        chk("latency_edge2", {40'd0, second}, 48'd0);
        chk("latency_edge2_pulse", {47'd0, sec_pulse}, 48'd0);
        cycles(1);
        chk("latency_edge3", {year, month, day, hour, minute, second}, tv(1, 1, 1, 0, 0, 1));
        chk("latency_edge3_pulse", {46'd0, sec_pulse, day_pulse}, {46'd0, 1'b1, 1'b0});
        cycles(1);
        chk("pulse_one_cycle", {47'd0, sec_pulse}, 48'd0);
        cycles(3);
        chk("no_retick_while_high", {40'd0, second}, 48'd1);
        clk1sec = 1'b0;
        cycles(3);

        load(tv(24, 2, 28, 23, 59, 59));
        chk("load_leap_setup", {year, month, day, hour, minute, second}, tv(24, 2, 28, 23, 59, 59));
        chk("load_no_pulse", {46'd0, sec_pulse, day_pulse}, 48'd0);
        tick_and_check("leap24", tv(24, 2, 29, 0, 0, 0), 1'b1);

        load(tv(100, 2, 28, 23, 59, 59));
        tick_and_check("nonleap100", tv(100, 3, 1, 0, 0, 0), 1'b1);

        load(tv(255, 12, 31, 23, 59, 59));
        tick_and_check("year_wrap", tv(0, 1, 1, 0, 0, 0), 1'b1);

        load(tv(0, 2, 28, 10, 0, 0));
        tick_and_check("no_day_carry", tv(0, 2, 28, 10, 0, 1), 1'b0);

        load(tv(5, 13, 0, 30, 70, 60));
        chk("sanitise_all", {year, month, day, hour, minute, second}, tv(5, 1, 1, 0, 0, 0));
        chk("sanitise_no_pulse", {46'd0, sec_pulse, day_pulse}, 48'd0);

        load(tv(5, 4, 31, 10, 20, 30));
        chk("clamp_april", {year, month, day, hour, minute, second}, tv(5, 4, 30, 10, 20, 30));

        load(tv(200, 2, 30, 1, 2, 3));
        chk("clamp_feb_200", {year, month, day, hour, minute, second}, tv(200, 2, 28, 1, 2, 3));

        // Load on the edge where the tick would land: tick is discarded, not deferred.
        clk1sec = 1'b1;
        cycles(2);
        bin_time = tv(9, 9, 9, 9, 9, 9);
        en_time  = 1'b1;
        cycles(1);
        en_time  = 1'b0;
        chk("coincide_load", {year, month, day, hour, minute, second}, tv(9, 9, 9, 9, 9, 9));
        chk("coincide_pulse", {47'd0, sec_pulse}, 48'd0);
        cycles(4);
        chk("coincide_not_deferred", {year, month, day, hour, minute, second}, tv(9, 9, 9, 9, 9, 9));
        clk1sec = 1'b0;
        cycles(3);

        // Reset mid-run is asynchronous; clk1sec high at release gives one tick on edge 3.
        clk1sec = 1'b1;
        cycles(1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("async_reset_time", {year, month, day, hour, minute, second}, tv(1, 1, 1, 0, 0, 0));
        chk("async_reset_pulses", {46'd0, sec_pulse, day_pulse}, 48'd0);
        @(negedge clk);
        rst = 1'b1;
        cycles(2);
        chk("release_edge2", {40'd0, second}, 48'd0);
        cycles(1);
        chk("release_tick", {year, month, day, hour, minute, second}, tv(1, 1, 1, 0, 0, 1));
        chk("release_tick_pulse", {47'd0, sec_pulse}, {47'd0, 1'b1});
        clk1sec = 1'b0;
        cycles(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
